// File: rtl/tag_pkg.sv
// tag_pkg: shared widths and lockout FSM states for the tag checker
package tag_pkg;
   localparam int DATA_SIZE  = 32;
   localparam int TAG_SIZE   = 8;
   localparam int NUM_BLOCKS = 4;
   localparam int KEY_SIZE   = 16;
   typedef enum logic {RUN, LOCKED} state_t;
endpackage

// File: rtl/tag_compute.sv
// tag_compute: keyed invert/rotate of each data block folded by XOR into a tag
module tag_compute
   import tag_pkg::*;
(
   input  logic [DATA_SIZE-1:0] data,
   input  logic [KEY_SIZE-1:0]  key,
   output logic [TAG_SIZE-1:0]  tag
);
   logic [TAG_SIZE-1:0] rot [NUM_BLOCKS];
   logic                unused_key;
   assign unused_key = ^{key[15], key[11], key[7]};
   for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
      logic [TAG_SIZE-1:0]   b;
      logic [2*TAG_SIZE-1:0] d;
      assign b = data[TAG_SIZE*i +: TAG_SIZE] ^ {TAG_SIZE{key[i]}};
      // rotate-left as the upper half of a doubled word shifted left
      assign d = {b, b} << key[4*i +: 3];
      assign rot[i] = d[2*TAG_SIZE-1:TAG_SIZE];
   end
   always_comb begin
      tag = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) tag ^= rot[i];
   end
endmodule

// File: rtl/tag_checker.sv
// tag_checker: two-stage keyed tag check with consecutive-failure lockout
module tag_checker #(
   parameter int DATA_SIZE  = 32,
   parameter int TAG_SIZE   = 8,
   parameter int FAIL_LIMIT = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 key_load,
   input  logic [15:0]          secret_key,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic [TAG_SIZE-1:0]  in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 out_pass,
   output logic [7:0]           fail_count,
   output logic                 locked,
   input  logic                 clear_lock
);
   import tag_pkg::*;
   logic [15:0]          key_q;
   logic                 s1_valid;
   logic [DATA_SIZE-1:0] s1_data;
   logic [TAG_SIZE-1:0]  s1_tag;
   logic [TAG_SIZE-1:0]  s1_exp;
   logic [TAG_SIZE-1:0]  exp_tag;
   logic [7:0]           cons_cnt;
   state_t               state;
   logic                 s2_adv;
   logic                 in_fire;
   logic                 out_fire;
   logic                 bad;
   tag_compute u_tag (.data(in_data), .key(key_q), .tag(exp_tag));
   assign s2_adv   = s1_valid && (!out_valid || out_ready);
   assign in_ready = (state == RUN) && (!s1_valid || s2_adv);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign bad      = out_fire && !out_pass;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_q     <= '0;
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s1_tag    <= '0;
         s1_exp    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_pass  <= 1'b0;
      end else begin
         if (key_load) key_q <= secret_key;
         s1_valid  <= in_fire || (s1_valid && !s2_adv);
         out_valid <= s2_adv || (out_valid && !out_ready);
         if (in_fire) begin
            s1_data <= in_data;
            s1_tag  <= in_tag;
            s1_exp  <= exp_tag;
         end
         if (s2_adv) begin
            out_data <= s1_data;
            out_pass <= s1_exp == s1_tag;
         end
      end
   end
   // clear_lock overrides a coincident failure for state and streak, not for the total
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         locked     <= 1'b0;
         cons_cnt   <= '0;
         fail_count <= '0;
      end else begin
         if (bad && fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
         cons_cnt <= clear_lock ? '0 : bad ? cons_cnt + 8'(cons_cnt != 8'hFF) : out_fire ? '0 : cons_cnt;
         if (clear_lock) begin
            state  <= RUN;
            locked <= 1'b0;
         end else if (state == RUN && bad && cons_cnt == 8'(FAIL_LIMIT - 1)) begin
            state  <= LOCKED;
            locked <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_tag_checker.sv
// tb_tag_checker: table-driven vectors plus lockout, backpressure and reset sequences
module tb_tag_checker;
   logic        clk;
   logic        reset;
   logic        key_load;
   logic [15:0] secret_key;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [7:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_pass;
   logic [7:0]  fail_count;
   logic        locked;
   logic        clear_lock;

   int checks = 0;
   int errors = 0;
   int exp_fails = 0;

   typedef struct {
      logic [15:0] key;
      logic [31:0] data;
      logic [7:0]  tag;
      logic        pass;
   } vec_t;
   vec_t vecs [10];

   logic [31:0] q [$];
   logic [31:0] prev_d;
   logic [31:0] exp_d;
   logic [7:0]  b;
   logic        stalled;
   int          sent;
   int          got;

   tag_checker #(.DATA_SIZE(32), .TAG_SIZE(8), .FAIL_LIMIT(3)) dut (
      .clk(clk), .reset(reset), .key_load(key_load), .secret_key(secret_key),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_pass(out_pass), .fail_count(fail_count), .locked(locked),
      .clear_lock(clear_lock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load_key(input logic [15:0] k);
      @(negedge clk);
      key_load = 1'b1;
      secret_key = k;
      clear_lock = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      clear_lock = 1'b0;
   endtask

   task automatic send_one(input logic [31:0] d, input logic [7:0] t, input logic p);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = d;
      in_tag = t;
      out_ready = 1'b1;
      #1 check("in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("lat1_valid", out_valid, 0);
      @(negedge clk);
      check("lat2_valid", out_valid, 1);
      check("out_data", out_data, d);
      check("out_pass", out_pass, p);
      if (!p) exp_fails++;
      @(negedge clk);
      check("fail_count", fail_count, exp_fails);
      check("drained", out_valid, 0);
   endtask

   initial begin
      vecs[0] = '{16'h0000, 32'h01020304, 8'h04, 1'b1};
      vecs[1] = '{16'h0010, 32'h01020304, 8'h01, 1'b1};
      vecs[2] = '{16'h0010, 32'h01020304, 8'h04, 1'b0};
      vecs[3] = '{16'h0001, 32'h01020304, 8'hF7, 1'b1};
      vecs[4] = '{16'h0000, 32'hDEADBEEF, 8'h22, 1'b1};
      vecs[5] = '{16'hFFFF, 32'h00000000, 8'h00, 1'b1};
      vecs[6] = '{16'hFFFF, 32'h00000000, 8'h01, 1'b0};
      vecs[7] = '{16'h2000, 32'h80000000, 8'h02, 1'b1};
      vecs[8] = '{16'h0300, 32'h00001100, 8'h11, 1'b1};
      vecs[9] = '{16'h0001, 32'h01020304, 8'hFB, 1'b0};
      reset = 1'b0;
      key_load = 1'b0;
      secret_key = '0;
      in_valid = 1'b0;
      in_data = '0;
      in_tag = '0;
      out_ready = 1'b0;
      clear_lock = 1'b0;
      #7;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pass", out_pass, 0);
      check("rst_out_data", out_data, 0);
      check("rst_fail_count", fail_count, 0);
      check("rst_locked", locked, 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         load_key(vecs[i].key);
         send_one(vecs[i].data, vecs[i].tag, vecs[i].pass);
      end

      // key loaded on the acceptance edge: beat uses the old key
      load_key(16'h0000);
      @(negedge clk);
      key_load = 1'b1;
      secret_key = 16'h0010;
      in_valid = 1'b1;
      in_data = 32'h01020304;
      in_tag = 8'h04;
      out_ready = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("oldkey_valid", out_valid, 1);
      check("oldkey_pass", out_pass, 1);
      send_one(32'h01020304, 8'h01, 1'b1);

      // lockout after three consecutive failures
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_fails = 0;
      for (int i = 0; i < 3; i++) send_one(32'h01020304, 8'h00, 1'b0);
      check("lock_locked", locked, 1);
      check("lock_in_ready", in_ready, 0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 32'h01020304;
      in_tag = 8'h04;
      #1 check("locked_in_ready", in_ready, 0);
      repeat (3) @(negedge clk);
      check("locked_no_out", out_valid, 0);
      in_valid = 1'b0;
      clear_lock = 1'b1;
      @(negedge clk);
      clear_lock = 1'b0;
      check("clear_locked", locked, 0);
      check("clear_in_ready", in_ready, 1);
      check("clear_fail_count", fail_count, 3);

      // clear_lock coinciding with the third consecutive failure
      send_one(32'h01020304, 8'h00, 1'b0);
      send_one(32'h01020304, 8'h00, 1'b0);
      check("coin_pre_locked", locked, 0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 32'h01020304;
      in_tag = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("coin_valid", out_valid, 1);
      @(negedge clk);
      check("coin_hold_valid", out_valid, 1);
      check("coin_hold_data", out_data, 32'h01020304);
      out_ready = 1'b1;
      clear_lock = 1'b1;
      @(negedge clk);
      clear_lock = 1'b0;
      exp_fails++;
      check("coin_locked", locked, 0);
      check("coin_fail_count", fail_count, exp_fails);
      send_one(32'h01020304, 8'h00, 1'b0);
      check("coin_post_locked", locked, 0);

      // back-to-back beats with out_ready toggling
      sent = 0;
      got = 0;
      stalled = 1'b0;
      prev_d = '0;
      for (int c = 0; c < 100 && got < 8; c++) begin
         @(negedge clk);
         if (stalled) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, prev_d);
         end
         out_ready = (c % 2 == 0);
         b = 8'(sent + 1);
         in_valid = sent < 8;
         in_data = {b, b, b ^ 8'h5A, b ^ 8'h5A};
         in_tag = 8'h00;
         #1;
         if (out_valid && out_ready) begin
            exp_d = q.size() > 0 ? q.pop_front() : 32'hDEADDEAD;
            check("bp_data", out_data, exp_d);
            check("bp_pass", out_pass, 1);
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            sent++;
         end
         stalled = out_valid && !out_ready;
         prev_d = out_data;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_got", got, 8);
      check("bp_left", q.size(), 0);
      repeat (3) begin
         @(negedge clk);
         check("bp_no_dup", out_valid, 0);
      end

      // reset with two beats in flight
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h11111111;
      in_tag = 8'h00;
      @(negedge clk);
      in_data = 32'h22222222;
      @(negedge clk);
      in_valid = 1'b0;
      check("flight_valid", out_valid, 1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_fail_count", fail_count, 0);
      check("mid_rst_locked", locked, 0);
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_no_out", out_valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
